mod_n_cascade_counter: RTL and testbench
========================================

// Module: mod_n_cascade_counter
// PURPOSE
// - Parametrised multi-digit modulo-N up/down counter; next generation of our single-digit mod-10 decade counter.
// - Adds per-digit modulus, digit cascading, count direction, count enable, synchronous clear and parallel load.
// - Adds a combinational terminal-count output for chaining counters, plus a registered wrap pulse.
// - Used for display digit counters, timebase prescalers and event counters on the lab boards.
// PARAMETERS
// - DIGITS   2   number of cascaded digits; digit 0 is least significant.
// - MOD      10  modulus of each digit; legal range 2 <= MOD <= 2**DIGIT_W.
// - DIGIT_W  4   bit width of one digit field.
// PORTS
// - clk       in   1                rising-edge clock.
// - reset     in   1                asynchronous, active-low; 0 clears all state immediately.
// - clr       in   1                synchronous clear, active-high.
// - load      in   1                synchronous parallel load, active-high.
// - load_val  in   DIGITS*DIGIT_W   load data; digit i is at [i*DIGIT_W +: DIGIT_W].
// - en        in   1                count enable; counts one step per clk while high.
// - up_dn     in   1                direction: 1 = up, 0 = down.
// - count     out  DIGITS*DIGIT_W   current count; packed the same way as load_val.
// - tc        out  1                terminal count, combinational. Equals en AND all digits at their end value
//                                   (MOD-1 when up_dn=1, 0 when up_dn=0).
// - wrap      out  1                registered; high for one cycle after the whole counter wraps.
// BEHAVIOUR
// - Reset (reset=0, asynchronous): count = 0, wrap = 0. tc then follows its combinational rule.
//   Reset asserted mid-count discards the count at once; counting resumes on the first clk edge after reset=1.
// - Per-edge priority: clr > load > en > hold. Only one action happens per edge.
// - clr=1: count <= 0, wrap <= 0.
// - load=1 (with clr=0): each digit i <= load_val digit i. A digit value >= MOD is loaded as 0.
//   wrap <= 0. en is ignored on that edge.
// - en=1, up count:
//   - Digit 0 increments. A digit at MOD-1 goes to 0 and carries into the next digit.
//   - Digit i changes only if all lower digits are at MOD-1.
// - en=1, down count:
//   - Digit 0 decrements. A digit at 0 goes to MOD-1 and borrows from the next digit.
//   - Digit i changes only if all lower digits are 0.
// - Whole-counter wrap:
//   - Up: all digits MOD-1 -> all digits 0.
//   - Down: all digits 0 -> all digits MOD-1.
//   - wrap <= 1 on the edge where tc=1 is consumed; otherwise wrap <= 0 on every edge.
// - en=0 and no clr/load: count holds, wrap <= 0.
// - Latency: count and wrap update on the edge where the action is sampled. tc has zero latency.
// - Changing up_dn between edges takes effect on the next edge, with no extra state. tc re-evaluates at once.
// - Cascading: drive the next counter's en from this counter's tc. The chain then behaves as one wider counter.
// - Arithmetic: all per-digit compares are against MOD-1 or 0, so there are no out-of-range states.
//   Unused codes (>= MOD) cannot be reached except through load, and load clamps them.
// - All registers use non-blocking assignment; no latches.
// TESTING (DIGITS=2, MOD=10 unless stated)
// - Reset: reset=0 mid-count at 37 -> count=0x00, wrap=0 with no clk edge.
//   Release, en=1 up -> 01, 02 on successive edges.
// - Up wrap: load 98, en=1 up -> 99 (tc=1) -> 00 with wrap=1 for exactly 1 cycle -> 01 with wrap=0.
// - Down borrow: load 10, en=1 down -> 09 -> 08. Load 00 down: tc=1 -> 99, wrap=1.
// - Priority: clr=1, load=1, en=1 at count 45 -> 00. load=1, en=1, load_val=72 -> 72, not 73.
// - Illegal load: load_val=0xA5 -> count=0x05. en=0 for 5 edges -> count holds 05, tc=0, wrap=0.
// - Param: DIGITS=3, MOD=6, DIGIT_W=3; count up from 000 -> after 216 en cycles back to 000, exactly one wrap pulse.

Source files
------------

// File: rtl/mod_n_cascade_counter.sv
// Multi-digit modulo-MOD up/down counter with per-digit carry/borrow cascading,
// synchronous clear and clamped parallel load, combinational tc and a registered wrap pulse.
module mod_n_cascade_counter #(
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned MOD     = 10,
    parameter int unsigned DIGIT_W = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        load,
    input  logic [DIGITS*DIGIT_W-1:0]   load_val,
    input  logic                        en,
    input  logic                        up_dn,
    output logic [DIGITS*DIGIT_W-1:0]   count,
    output logic                        tc,
    output logic                        wrap
);

    localparam logic [DIGIT_W-1:0] DigMax = DIGIT_W'(MOD - 1);
    // One extra bit so MOD == 2**DIGIT_W is representable for the load clamp.
    localparam logic [DIGIT_W:0]   ModExt = (DIGIT_W + 1)'(MOD);

    logic [DIGIT_W-1:0] digit_q [DIGITS];
    logic [DIGIT_W-1:0] digit_d [DIGITS];
    logic [DIGITS-1:0]  at_max;
    logic [DIGITS-1:0]  at_zero;
    logic [DIGITS-1:0]  step_up;
    logic [DIGITS-1:0]  step_dn;
    logic               all_max;
    logic               all_zero;
    logic               wrap_q;
    logic               wrap_d;

    always_comb begin
        logic               run_up;
        logic               run_dn;
        logic [DIGIT_W-1:0] ld_dig;

        at_max   = '0;
        at_zero  = '0;
        step_up  = '0;
        step_dn  = '0;
        run_up   = 1'b1;
        run_dn   = 1'b1;
        ld_dig   = '0;

        // A digit steps only when every lower digit sits at its end value.
        for (int i = 0; i < int'(DIGITS); i++) begin
            at_max[i]  = (digit_q[i] == DigMax);
            at_zero[i] = (digit_q[i] == '0);
            step_up[i] = run_up;
            step_dn[i] = run_dn;
            run_up     = run_up & at_max[i];
            run_dn     = run_dn & at_zero[i];
        end
        all_max  = run_up;
        all_zero = run_dn;

        tc     = en & (up_dn ? all_max : all_zero);
        wrap_d = tc & ~clr & ~load;

        for (int i = 0; i < int'(DIGITS); i++) begin
            ld_dig     = load_val[i*DIGIT_W +: DIGIT_W];
            digit_d[i] = digit_q[i];
            if (clr) begin
                digit_d[i] = '0;
            end else if (load) begin
                digit_d[i] = ({1'b0, ld_dig} >= ModExt) ? '0 : ld_dig;
            end else if (en && up_dn && step_up[i]) begin
                digit_d[i] = at_max[i] ? '0 : digit_q[i] + DIGIT_W'(1);
            end else if (en && !up_dn && step_dn[i]) begin
                digit_d[i] = at_zero[i] ? DigMax : digit_q[i] - DIGIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                digit_q[i] <= '0;
            end
            wrap_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                digit_q[i] <= digit_d[i];
            end
            wrap_q <= wrap_d;
        end
    end

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_pack
        assign count[g*DIGIT_W +: DIGIT_W] = digit_q[g];
    end

    assign wrap = wrap_q;

endmodule

// File: tb/tb_mod_n_cascade_counter.sv
// Directed bench for mod_n_cascade_counter: a 2-digit decade instance checked through an
// expected-value queue, plus a 3-digit mod-6 instance run through a full cycle.
module tb_mod_n_cascade_counter;

    logic       clk;
    logic       reset;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic       en;
    logic       up_dn;
    logic [7:0] count;
    logic       tc;
    logic       wrap;

    logic       en_b;
    logic       tie_lo;
    logic       tie_hi;
    logic [8:0] load_val_b;
    logic [8:0] count_b;
    logic       tc_b;
    logic       wrap_b;

    int n_tests;
    int n_fail;
    int wraps_b;

    typedef struct packed {
        logic [7:0] c;
        logic       tc;
        logic       wr;
    } exp_t;

    exp_t sb[$];

    mod_n_cascade_counter #(
        .DIGITS  (2),
        .MOD     (10),
        .DIGIT_W (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .up_dn    (up_dn),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap)
    );

    mod_n_cascade_counter #(
        .DIGITS  (3),
        .MOD     (6),
        .DIGIT_W (3)
    ) dut_b (
        .clk      (clk),
        .reset    (reset),
        .clr      (tie_lo),
        .load     (tie_lo),
        .load_val (load_val_b),
        .en       (en_b),
        .up_dn    (tie_hi),
        .count    (count_b),
        .tc       (tc_b),
        .wrap     (wrap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL %s: no expected entry queued", tag);
            return;
        end
        e = sb.pop_front();
        assert (count === e.c && tc === e.tc && wrap === e.wr) else begin
            n_fail++;
            $error("FAIL %s: got count=%h tc=%b wrap=%b, expected count=%h tc=%b wrap=%b",
                   tag, count, tc, wrap, e.c, e.tc, e.wr);
        end
    endtask

    // Apply inputs, queue the expected post-edge state, clock once, compare.
    task automatic step(input logic c_clr, input logic c_load, input logic [7:0] c_lv,
                        input logic c_en, input logic c_up, input logic [7:0] e_c,
                        input logic e_tc, input logic e_wr, input string tag);
        clr      = c_clr;
        load     = c_load;
        load_val = c_lv;
        en       = c_en;
        up_dn    = c_up;
        sb.push_back('{c: e_c, tc: e_tc, wr: e_wr});
        @(posedge clk);
        #1;
        check(tag);
    endtask

    // Compare without a clock edge (async reset, combinational tc).
    task automatic look(input logic [7:0] e_c, input logic e_tc, input logic e_wr,
                        input string tag);
        sb.push_back('{c: e_c, tc: e_tc, wr: e_wr});
        #1;
        check(tag);
    endtask

    initial begin
        int n;
        logic [8:0] exp_b;

        n_tests    = 0;
        n_fail     = 0;
        wraps_b    = 0;
        reset      = 1'b0;
        clr        = 1'b0;
        load       = 1'b0;
        load_val   = '0;
        en         = 1'b0;
        up_dn      = 1'b1;
        en_b       = 1'b0;
        tie_lo     = 1'b0;
        tie_hi     = 1'b1;
        load_val_b = '0;

        #2;
        look(8'h00, 1'b0, 1'b0, "reset_initial");
        reset = 1'b1;

        // Reset mid-count clears at once, counting restarts from 00.
        step(1'b0, 1'b1, 8'h37, 1'b0, 1'b1, 8'h37, 1'b0, 1'b0, "load_37");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h38, 1'b0, 1'b0, "up_38");
        #2;
        reset = 1'b0;
        look(8'h00, 1'b0, 1'b0, "async_reset");
        reset = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, "post_reset_01");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, "post_reset_02");

        // Up wrap.
        step(1'b0, 1'b1, 8'h98, 1'b1, 1'b1, 8'h98, 1'b0, 1'b0, "load_98");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0, "up_99_tc");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, "up_wrap");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, "up_after_wrap");

        // Down borrow and down wrap.
        step(1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, "load_10");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0, "down_borrow_09");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h08, 1'b0, 1'b0, "down_08");
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "load_00_tc_down");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h99, 1'b0, 1'b1, "down_wrap");
        up_dn = 1'b1;
        look(8'h99, 1'b1, 1'b1, "dir_flip_tc");
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0, "hold_99_en0");

        // Priority: clr > load > en; clr and load both suppress wrap.
        step(1'b0, 1'b1, 8'h45, 1'b0, 1'b1, 8'h45, 1'b0, 1'b0, "load_45");
        step(1'b1, 1'b1, 8'h72, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, "clr_beats_all");
        step(1'b0, 1'b1, 8'h72, 1'b1, 1'b1, 8'h72, 1'b0, 1'b0, "load_beats_en");
        step(1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0, "load_99");
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, "clr_no_wrap");
        step(1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0, "reload_99");
        step(1'b0, 1'b1, 8'h99, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0, "load_no_wrap");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, "wrap_after_load");

        // Illegal digit values clamp to 0; en=0 holds.
        step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, "load_A5");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, "hold_05");
        end
        step(1'b0, 1'b1, 8'h3F, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0, "load_3F");
        step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "load_FF");
        load = 1'b0;

        // 3-digit mod-6 counter: 216 steps return to 000 with exactly one wrap.
        en_b = 1'b1;
        for (int i = 1; i <= 216; i++) begin
            @(posedge clk);
            #1;
            n     = i % 216;
            exp_b = {3'(n / 36), 3'((n / 6) % 6), 3'(n % 6)};
            if (wrap_b === 1'b1) wraps_b++;
            n_tests++;
            assert (count_b === exp_b && wrap_b === (i == 216) && tc_b === (n == 215)) else begin
                n_fail++;
                $error("FAIL mod6_step%0d: got count=%o tc=%b wrap=%b, expected count=%o tc=%b wrap=%b",
                       i, count_b, tc_b, wrap_b, exp_b, (n == 215), (i == 216));
            end
        end
        en_b = 1'b0;
        @(posedge clk);
        #1;
        if (wrap_b === 1'b1) wraps_b++;
        n_tests++;
        assert (wraps_b == 1 && count_b === 9'o000) else begin
            n_fail++;
            $error("FAIL mod6_wrap_count: got wraps=%0d count=%o, expected wraps=1 count=000",
                   wraps_b, count_b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
